// File: rtl/bot_update_sched_if.sv
// Bus bundle for bot_update_sched: bot register inputs, PicoBlaze handshake,
// vblank pulse and the CPU/video register outputs.
interface bot_update_sched_if #(
   parameter int unsigned OVR_W = 8
);
   logic             upd_sysregs;
   logic [7:0]       LocX_in;
   logic [7:0]       LocY_in;
   logic [7:0]       BotInfo_in;
   logic [7:0]       Sensors_in;
   logic             interrupt_ack;
   logic             vblank_start;
   logic             interrupt;
   logic [7:0]       LocX_cpu;
   logic [7:0]       LocY_cpu;
   logic [7:0]       BotInfo_cpu;
   logic [7:0]       Sensors_cpu;
   logic [7:0]       LocX_vid;
   logic [7:0]       LocY_vid;
   logic [7:0]       BotInfo_vid;
   logic [OVR_W-1:0] overrun_cnt;

   modport slave (
      input  upd_sysregs, LocX_in, LocY_in, BotInfo_in, Sensors_in,
      input  interrupt_ack, vblank_start,
      output interrupt, LocX_cpu, LocY_cpu, BotInfo_cpu, Sensors_cpu,
      output LocX_vid, LocY_vid, BotInfo_vid, overrun_cnt
   );

   modport master (
      output upd_sysregs, LocX_in, LocY_in, BotInfo_in, Sensors_in,
      output interrupt_ack, vblank_start,
      input  interrupt, LocX_cpu, LocY_cpu, BotInfo_cpu, Sensors_cpu,
      input  LocX_vid, LocY_vid, BotInfo_vid, overrun_cnt
   );
endinterface

// File: rtl/bot_update_sched.sv
// Bot register update scheduler: CPU snapshot + interrupt with timeout retry,
// and a vblank-synchronised video shadow. BOT_SCHED_OVERRUN_CNT_EN builds the overrun counter.
module bot_update_sched #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
   parameter int unsigned OVR_W          = 8
) (
   input logic               sysclk,
   input logic               sysreset,
   bot_update_sched_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RETRY = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] tmo_q, tmo_d;
   logic        interrupt_q, interrupt_d;
   logic [7:0]  locx_cpu_q, locx_cpu_d;
   logic [7:0]  locy_cpu_q, locy_cpu_d;
   logic [7:0]  info_cpu_q, info_cpu_d;
   logic [7:0]  sens_cpu_q, sens_cpu_d;
   logic [7:0]  locx_pend_q, locx_pend_d;
   logic [7:0]  locy_pend_q, locy_pend_d;
   logic [7:0]  info_pend_q, info_pend_d;
   logic        vid_dirty_q, vid_dirty_d;
   logic [7:0]  locx_vid_q, locx_vid_d;
   logic [7:0]  locy_vid_q, locy_vid_d;
   logic [7:0]  info_vid_q, info_vid_d;

   // Request FSM, CPU snapshot and video double-buffer
   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      locx_cpu_d  = locx_cpu_q;
      locy_cpu_d  = locy_cpu_q;
      info_cpu_d  = info_cpu_q;
      sens_cpu_d  = sens_cpu_q;
      locx_pend_d = locx_pend_q;
      locy_pend_d = locy_pend_q;
      info_pend_d = info_pend_q;
      vid_dirty_d = vid_dirty_q;
      locx_vid_d  = locx_vid_q;
      locy_vid_d  = locy_vid_q;
      info_vid_d  = info_vid_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.upd_sysregs) begin
               locx_cpu_d = bus.LocX_in;
               locy_cpu_d = bus.LocY_in;
               info_cpu_d = bus.BotInfo_in;
               sens_cpu_d = bus.Sensors_in;
               tmo_d      = 16'd0;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack takes priority over both the timeout and a concurrent update
            if (bus.interrupt_ack) begin
               tmo_d   = 16'd0;
               state_d = ST_IDLE;
            end else if (tmo_q == 16'(TIMEOUT_CYCLES - 16'd1)) begin
               tmo_d   = 16'd0;
               state_d = ST_RETRY;
            end else begin
               tmo_d = 16'(tmo_q + 16'd1);
            end
         end
         ST_RETRY: begin
            tmo_d   = 16'd0;
            state_d = ST_REQ;
         end
         default: begin
            tmo_d   = 16'd0;
            state_d = ST_IDLE;
         end
      endcase

      interrupt_d = (state_d == ST_REQ);

      // Publish the old buffer first so a same-cycle update stays pending
      if (bus.vblank_start && vid_dirty_q) begin
         locx_vid_d  = locx_pend_q;
         locy_vid_d  = locy_pend_q;
         info_vid_d  = info_pend_q;
         vid_dirty_d = 1'b0;
      end
      if (bus.upd_sysregs) begin
         locx_pend_d = bus.LocX_in;
         locy_pend_d = bus.LocY_in;
         info_pend_d = bus.BotInfo_in;
         vid_dirty_d = 1'b1;
      end
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state_q     <= ST_IDLE;
         tmo_q       <= 16'd0;
         interrupt_q <= 1'b0;
         locx_cpu_q  <= 8'h00;
         locy_cpu_q  <= 8'h00;
         info_cpu_q  <= 8'h00;
         sens_cpu_q  <= 8'h00;
         locx_pend_q <= 8'h00;
         locy_pend_q <= 8'h00;
         info_pend_q <= 8'h00;
         vid_dirty_q <= 1'b0;
         locx_vid_q  <= 8'h00;
         locy_vid_q  <= 8'h00;
         info_vid_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         interrupt_q <= interrupt_d;
         locx_cpu_q  <= locx_cpu_d;
         locy_cpu_q  <= locy_cpu_d;
         info_cpu_q  <= info_cpu_d;
         sens_cpu_q  <= sens_cpu_d;
         locx_pend_q <= locx_pend_d;
         locy_pend_q <= locy_pend_d;
         info_pend_q <= info_pend_d;
         vid_dirty_q <= vid_dirty_d;
         locx_vid_q  <= locx_vid_d;
         locy_vid_q  <= locy_vid_d;
         info_vid_q  <= info_vid_d;
      end
   end

`ifdef BOT_SCHED_OVERRUN_CNT_EN
   logic [OVR_W-1:0] ovr_q, ovr_d;

   // Updates that arrive while a request is outstanding are dropped and counted
   always_comb begin
      ovr_d = ovr_q;
      if (bus.upd_sysregs && (state_q != ST_IDLE) && (ovr_q != {OVR_W{1'b1}})) begin
         ovr_d = OVR_W'(ovr_q + OVR_W'(1));
      end
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         ovr_q <= OVR_W'(0);
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign bus.overrun_cnt = ovr_q;
`else
   assign bus.overrun_cnt = OVR_W'(0);
`endif

   assign bus.interrupt   = interrupt_q;
   assign bus.LocX_cpu    = locx_cpu_q;
   assign bus.LocY_cpu    = locy_cpu_q;
   assign bus.BotInfo_cpu = info_cpu_q;
   assign bus.Sensors_cpu = sens_cpu_q;
   assign bus.LocX_vid    = locx_vid_q;
   assign bus.LocY_vid    = locy_vid_q;
   assign bus.BotInfo_vid = info_vid_q;

endmodule

// File: doc/bot_update_sched.md
BOT_UPDATE_SCHED -- requirements
Module: bot_update_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1000: cycles in REQ without interrupt_ack before a retry.
REQ-002 Parameter OVR_W, default 8: overrun counter width.
REQ-003 sysclk  input  1  system clock (66 MHz); all logic on its rising edge.
REQ-004 sysreset  input  1  reset; asynchronous, active-high.
REQ-005 upd_sysregs  input  1  single-cycle pulse from bot; bot registers are valid.
REQ-006 LocX_in, LocY_in, BotInfo_in, Sensors_in  input  8 each  live bot registers.
REQ-007 interrupt_ack  input  1  single-cycle PicoBlaze acknowledge.
REQ-008 vblank_start  input  1  single-cycle pulse at the first non-video_on line of a frame.
REQ-009 interrupt  output  1  level interrupt to PicoBlaze.
REQ-010 LocX_cpu, LocY_cpu, BotInfo_cpu, Sensors_cpu  output  8 each  CPU snapshot, stable while interrupt is high.
REQ-011 LocX_vid, LocY_vid, BotInfo_vid  output  8 each  video shadow, changes only on vblank_start.
REQ-012 overrun_cnt  output  OVR_W  count of updates dropped while a request was pending.

Function
REQ-013 FSM has three states: IDLE, REQ, RETRY.
REQ-014 IDLE: upd_sysregs captures all four inputs into the CPU snapshot on the same edge; next state REQ; interrupt=1 from the following cycle.
REQ-015 REQ: interrupt=1; interrupt_ack -> IDLE with interrupt=0 on the next cycle.
REQ-016 REQ: the timeout counter increments each cycle; at TIMEOUT_CYCLES-1 with no ack -> RETRY.
REQ-017 RETRY: interrupt=0 for exactly one cycle, counter cleared, then back to REQ with the snapshot unchanged.
REQ-018 interrupt_ack in IDLE or RETRY is ignored.
REQ-019 upd_sysregs in REQ or RETRY does not alter the CPU snapshot and increments overrun_cnt, saturating at all-ones.
REQ-020 upd_sysregs and interrupt_ack on the same cycle in REQ: ack wins and the state goes to IDLE; the update counts as an overrun; no new capture.
REQ-021 Every upd_sysregs in any state also captures LocX, LocY and BotInfo into a pending-video buffer and sets vid_dirty.
REQ-022 vblank_start with vid_dirty=1 copies the pending-video buffer to the *_vid outputs and clears vid_dirty; with vid_dirty=0 there is no change.
REQ-023 vblank_start and upd_sysregs on the same cycle: the *_vid outputs take the old buffer; the new data is captured; vid_dirty stays 1.
REQ-024 The timeout counter is 16 bits and is cleared on entry to REQ.

Reset
REQ-025 Asynchronous reset forces IDLE, interrupt=0, all snapshot, buffer and *_vid outputs to 8'h00, vid_dirty=0, overrun_cnt=0, timeout counter=0.
REQ-026 Reset in REQ drops interrupt in the same instant and discards the pending request.
REQ-027 After reset is released, the first upd_sysregs is handled as in REQ-014.

Configuration
REQ-028 Macro BOT_SCHED_OVERRUN_CNT_EN.
REQ-029 Defined: overrun_cnt behaves per REQ-019 and REQ-020.
REQ-030 Undefined: overrun_cnt is tied to 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-031 Reset, then upd_sysregs with LocX=8'h3C, LocY=8'h51 -> next cycle interrupt=1 and LocX_cpu=8'h3C, LocY_cpu=8'h51; ack 5 cycles later -> interrupt=0 on the following cycle.
REQ-032 Hold REQ with no ack and TIMEOUT_CYCLES=10 -> interrupt low for exactly 1 cycle after 10 cycles, then high again; snapshot unchanged.
REQ-033 Three upd_sysregs pulses during REQ with new values -> CPU snapshot keeps the first values; overrun_cnt=3 (0 with the macro undefined).
REQ-034 upd_sysregs with LocX=8'h10, then vblank_start 20 cycles later -> LocX_vid=8'h10 only after vblank_start; a second vblank_start with no update -> no change.
REQ-035 Same-cycle upd_sysregs and interrupt_ack in REQ -> IDLE, overrun_cnt +1; same-cycle vblank_start and upd_sysregs -> old buffer shown, vid_dirty=1.
REQ-036 Assert sysreset mid-REQ, asynchronous to sysclk -> interrupt=0 immediately; all outputs 0; overrun_cnt=8'hFF saturation check after 260 overruns.
